// File: rtl/instruction_fetch_unit.sv
// Fetch front-end: owns the PC, runs the req/ack handshake to instruction memory and
// feeds the IF/ID register from a 2-entry queue. Define FETCH_PERF_CNT_EN for perf counters.
`timescale 1ns/1ps
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PCWrite,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemAck,
  input  logic [31:0] IMemData,
  output logic [31:0] Instruction,
  output logic [31:0] PC,
  output logic        FetchValid,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] StallCycles,
  output logic [31:0] FlushCount,
`endif
  output logic        IF_Flush
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      state, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] drain_addr, drain_addr_next;
  logic [31:0] target_aligned;

  logic [31:0] head_instr, head_pc4, tail_instr, tail_pc4;
  logic        head_valid, tail_valid;
  logic [31:0] head_instr_next, head_pc4_next, tail_instr_next, tail_pc4_next;
  logic        head_valid_next, tail_valid_next;

  logic        if_flush_reg;
  logic        fetching, pop, push;
  logic [1:0]  count, count_after_pop, count_after_push;

  assign target_aligned   = BranchTarget & 32'hFFFF_FFFC;
  assign fetching         = (state == S_REQ) || (state == S_WAIT);
  assign pop              = PCWrite && head_valid;
  // Data arriving in DRAIN, or in the same cycle as a redirect, belongs to the dead path.
  assign push             = IMemAck && fetching && !PCSrc;
  assign count            = {1'b0, head_valid} + {1'b0, tail_valid};
  assign count_after_pop  = count - {1'b0, pop};
  assign count_after_push = count_after_pop + {1'b0, push};

  // Next-state, PC and abandoned-address bookkeeping; a redirect overrides everything else.
  always_comb begin
    state_next      = state;
    pc_next         = pc_reg;
    drain_addr_next = drain_addr;
    if (PCSrc) begin
      pc_next = target_aligned;
      if (state == S_DRAIN) begin
        state_next = IMemAck ? S_REQ : S_DRAIN;
      end else if (fetching && !IMemAck) begin
        state_next      = S_DRAIN;
        drain_addr_next = pc_reg;
      end else begin
        state_next = S_REQ;
      end
    end else begin
      case (state)
        S_REQ, S_WAIT: begin
          if (IMemAck) begin
            pc_next    = pc_reg + 32'd4;
            state_next = (count_after_push <= 2'd1) ? S_REQ : S_HOLD;
          end else begin
            state_next = S_WAIT;
          end
        end
        S_HOLD: begin
          if (pop) state_next = S_REQ;
        end
        S_DRAIN: begin
          if (IMemAck) state_next = S_REQ;
        end
        default: state_next = S_REQ;
      endcase
    end
  end

  // Queue update: pop shifts the skid entry forward, then a push fills the first free slot.
  always_comb begin
    head_instr_next = head_instr;
    head_pc4_next   = head_pc4;
    head_valid_next = head_valid;
    tail_instr_next = tail_instr;
    tail_pc4_next   = tail_pc4;
    tail_valid_next = tail_valid;
    if (PCSrc) begin
      head_valid_next = 1'b0;
      tail_valid_next = 1'b0;
    end else begin
      if (pop) begin
        head_instr_next = tail_instr;
        head_pc4_next   = tail_pc4;
        head_valid_next = tail_valid;
        tail_valid_next = 1'b0;
      end
      if (push) begin
        if (!head_valid_next) begin
          head_instr_next = IMemData;
          head_pc4_next   = pc_reg + 32'd4;
          head_valid_next = 1'b1;
        end else begin
          tail_instr_next = IMemData;
          tail_pc4_next   = pc_reg + 32'd4;
          tail_valid_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state        <= S_REQ;
      pc_reg       <= RESET_PC;
      drain_addr   <= '0;
      head_instr   <= '0;
      head_pc4     <= '0;
      head_valid   <= 1'b0;
      tail_instr   <= '0;
      tail_pc4     <= '0;
      tail_valid   <= 1'b0;
      if_flush_reg <= 1'b0;
    end else begin
      state        <= state_next;
      pc_reg       <= pc_next;
      drain_addr   <= drain_addr_next;
      head_instr   <= head_instr_next;
      head_pc4     <= head_pc4_next;
      head_valid   <= head_valid_next;
      tail_instr   <= tail_instr_next;
      tail_pc4     <= tail_pc4_next;
      tail_valid   <= tail_valid_next;
      if_flush_reg <= PCSrc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      if (head_valid && !PCWrite && (StallCycles != 32'hFFFF_FFFF))
        StallCycles <= StallCycles + 32'd1;
      if (PCSrc && (FlushCount != 32'hFFFF_FFFF))
        FlushCount <= FlushCount + 32'd1;
    end
  end
`endif

  // Request is gated by Reset so an abandoned fetch disappears without waiting for a clock.
  assign IMemReq     = (state != S_HOLD) && !Reset;
  assign IMemAddr    = (state == S_DRAIN) ? drain_addr : pc_reg;
  assign FetchValid  = head_valid;
  assign Instruction = head_valid ? head_instr : 32'h0;
  assign PC          = head_valid ? head_pc4 : 32'h0;
  assign IF_Flush    = if_flush_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases with a variable-latency
// memory model; fetch addresses and accepted outputs are checked in order by a monitor.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write, pc_src;
  logic [31:0] branch_target;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_data, instruction, pc_out;
  logic        fetch_valid, if_flush;

  logic        w_req, w_valid, w_flush;
  logic [31:0] w_addr, w_data, w_instr, w_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_count, w_stall_cycles, w_flush_count;
`endif

  int          lat = 0;
  int          wait_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  int          accepted = 0;
  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_out_q[$];
  logic [63:0] exp_entry;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(clk), .Reset(rst), .PCWrite(pc_write), .PCSrc(pc_src),
    .BranchTarget(branch_target), .IMemReq(imem_req), .IMemAddr(imem_addr),
    .IMemAck(imem_ack), .IMemData(imem_data), .Instruction(instruction),
    .PC(pc_out), .FetchValid(fetch_valid),
`ifdef FETCH_PERF_CNT_EN
    .StallCycles(stall_cycles), .FlushCount(flush_count),
`endif
    .IF_Flush(if_flush)
  );

  // Second instance exercises PC wrap-around from the top of the address space.
  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .Clk(clk), .Reset(rst), .PCWrite(1'b1), .PCSrc(1'b0),
    .BranchTarget(32'h0), .IMemReq(w_req), .IMemAddr(w_addr),
    .IMemAck(w_req), .IMemData(w_data), .Instruction(w_instr),
    .PC(w_pc), .FetchValid(w_valid),
`ifdef FETCH_PERF_CNT_EN
    .StallCycles(w_stall_cycles), .FlushCount(w_flush_count),
`endif
    .IF_Flush(w_flush)
  );

  assign w_data = mem_word(w_addr);

  // Memory acks after 'lat' waiting cycles (lat = 0 acks in the request cycle).
  always @(posedge clk or posedge rst) begin
    if (rst) wait_cnt <= 0;
    else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
  end
  assign imem_ack  = imem_req && (wait_cnt >= lat);
  assign imem_data = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic noteUnexpected(input string name, input logic [31:0] actual);
    checks++;
    failures++;
    $display("[TB] FAIL %s: got %h, expected nothing at %0t", name, actual, $time);
  endtask

  task automatic applyStimulus(input logic pw, input logic src, input logic [31:0] bt);
    pc_write      = pw;
    pc_src        = src;
    branch_target = bt;
  endtask

  task automatic expectAddrs(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) exp_addr_q.push_back(first + 32'(4 * i));
  endtask

  task automatic expectOuts(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++)
      exp_out_q.push_back({mem_word(first + 32'(4 * i)), first + 32'(4 * i) + 32'd4});
  endtask

  task automatic waitAccepts(input int target);
    int n = 0;
    while (accepted < target && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    checkOutput("accept_count", accepted, target);
  endtask

  task automatic waitHold();
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (imem_req && n < 50);
    checkOutput("hold_req_low", {31'b0, imem_req}, 32'h0);
  endtask

  // Monitor: every handshake and every accepted head is matched against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req && imem_ack) begin
        if (exp_addr_q.size() == 0) noteUnexpected("fetch_addr", imem_addr);
        else checkOutput("fetch_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (fetch_valid && pc_write) begin
        accepted++;
        if (exp_out_q.size() == 0) begin
          noteUnexpected("instr", instruction);
        end else begin
          exp_entry = exp_out_q.pop_front();
          checkOutput("instr", instruction, exp_entry[63:32]);
          checkOutput("pc4", pc_out, exp_entry[31:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    #1 rst = 1'b1;
    #2;
    checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("rst_instr", instruction, 32'h0);
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_flush", {31'b0, if_flush}, 32'h0);

    // Zero-latency streaming from address 0, then stall until the queue fills.
    expectAddrs(32'h0, 7);
    expectOuts(32'h0, 5);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    checkOutput("first_addr", imem_addr, 32'h0);
    checkOutput("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    checkOutput("wrap_instr0", w_instr, mem_word(32'hFFFF_FFFC));
    checkOutput("wrap_pc0", w_pc, 32'h0);
    checkOutput("wrap_addr1", w_addr, 32'h0);
    @(negedge clk); #1;
    checkOutput("wrap_instr1", w_instr, mem_word(32'h0));
    checkOutput("wrap_pc1", w_pc, 32'h4);
    waitAccepts(5);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    waitHold();
    checkOutput("hold_valid", {31'b0, fetch_valid}, 32'h1);
    checkOutput("hold_instr", instruction, mem_word(32'h14));
    checkOutput("hold_pc", pc_out, 32'h18);

    // Redirect with a full queue and PCWrite = 0; low target bits must be ignored.
    expectAddrs(32'h40, 8);
    expectOuts(32'h40, 6);
    @(posedge clk); #1;
    lat = 2;
    applyStimulus(1'b0, 1'b1, 32'h43);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("redir_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("redir_flush", {31'b0, if_flush}, 32'h1);
    checkOutput("redir_addr", imem_addr, 32'h40);
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("redir_flush_end", {31'b0, if_flush}, 32'h0);

    // Latency 2 with a mid-stream stall long enough to reach HOLD.
    waitAccepts(7);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    waitHold();
    checkOutput("stall_instr", instruction, mem_word(32'h48));
    checkOutput("stall_pc", pc_out, 32'h4C);
    repeat (2) @(posedge clk);
    #1 applyStimulus(1'b1, 1'b0, 32'h0);
    waitAccepts(11);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    waitHold();

    // Latency 3: redirect to 0x100 while the fetch of 0x20 is outstanding.
    exp_addr_q.push_back(32'h20);
    expectAddrs(32'h100, 5);
    expectOuts(32'h100, 4);
    @(posedge clk); #1;
    lat = 3;
    applyStimulus(1'b0, 1'b1, 32'h20);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("br_flush_a", {31'b0, if_flush}, 32'h1);
    checkOutput("br_req_addr", imem_addr, 32'h20);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b1, 32'h100);
    @(negedge clk); #1;
    checkOutput("br_flush_gap", {31'b0, if_flush}, 32'h0);
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("br_flush_b", {31'b0, if_flush}, 32'h1);
    checkOutput("drain_addr", imem_addr, 32'h20);
    checkOutput("drain_req", {31'b0, imem_req}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("br_flush_b_end", {31'b0, if_flush}, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("br_new_addr", imem_addr, 32'h100);
    waitAccepts(14);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    waitHold();

    // Reset between edges while a fetch is outstanding.
    @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 32'h0);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    checkOutput("pre_rst_req", {31'b0, imem_req}, 32'h1);
    checkOutput("pre_rst_instr", instruction, mem_word(32'h110));
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_req", {31'b0, imem_req}, 32'h0);
    checkOutput("mid_rst_valid", {31'b0, fetch_valid}, 32'h0);
    checkOutput("mid_rst_instr", instruction, 32'h0);
    checkOutput("mid_rst_pc", pc_out, 32'h0);
    checkOutput("mid_rst_flush", {31'b0, if_flush}, 32'h0);
    expectAddrs(32'h0, 3);
    expectOuts(32'h0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk); #1;
    checkOutput("post_rst_req", {31'b0, imem_req}, 32'h1);
    checkOutput("post_rst_addr", imem_addr, 32'h0);
    waitAccepts(16);
    @(posedge clk); #1 applyStimulus(1'b0, 1'b0, 32'h0);
    waitHold();

    checkOutput("addr_q_left", exp_addr_q.size(), 32'h0);
    checkOutput("out_q_left", exp_out_q.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
